// File: rtl/gf_pkg.sv
// Shared widths, FSM encoding and constant-tap carry-less multiply for the GF(2^64) reducer.
package gf_pkg;

  localparam int GF_W   = 64;
  localparam int PROD_W = 127;
  localparam logic [31:0] DEFAULT_POLY_LOW = 32'h0000_001B;

  typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, VALID} state_t;

  // Taps are a parameter at every call site, so this collapses to a fixed XOR network.
  function automatic logic [PROD_W-1:0] clmul_const(input logic [PROD_W-1:0] x,
                                                     input logic [31:0]       taps);
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      if (taps[k]) acc = acc ^ (x << k);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf64_reduce_seq_if.sv
// Product-in / remainder-out handshake bundle for gf64_reduce_seq.
interface gf64_reduce_seq_if;
  import gf_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [GF_W-1:0]   out_rem;
  logic              busy;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_rem, busy
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_rem, busy
  );

endinterface

// File: rtl/gf_fold.sv
// One combinational fold: din[63:0] ^ clmul(din[IN_W-1:64], POLY_LOW), kept OUT_W bits wide.
module gf_fold
  import gf_pkg::*;
#(
  parameter int          IN_W     = PROD_W,
  parameter int          OUT_W    = PROD_W - 32,
  parameter logic [31:0] POLY_LOW = DEFAULT_POLY_LOW
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [PROD_W-1:0] h_ext;
  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  l_ext;
  logic              unused_hi;

  assign h_ext = PROD_W'(din[IN_W-1:GF_W]);
  assign prod  = clmul_const(h_ext, POLY_LOW);
  assign l_ext = OUT_W'(din[GF_W-1:0]);
  assign dout  = l_ext ^ prod[OUT_W-1:0];

  // With POLY_LOW of degree <= 31 these product bits are always zero.
  assign unused_hi = ^prod[PROD_W-1:OUT_W];

endmodule

// File: rtl/gf64_reduce_seq.sv
// Reduces a 127-bit carry-less product mod x^64 + POLY_LOW in two registered folds.
// Result is valid three edges after accept and is held until out_ready.
module gf64_reduce_seq
  import gf_pkg::*;
#(
  parameter logic [31:0] POLY_LOW = DEFAULT_POLY_LOW
) (
  input  logic              clk,
  input  logic              rst,
  gf64_reduce_seq_if.slave  bus
);

  localparam int R1_W = PROD_W - 32;

  state_t            state;
  logic [PROD_W-1:0] p_reg;
  logic [R1_W-1:0]   r1;
  logic [R1_W-1:0]   r1_next;
  logic [GF_W-1:0]   rem_next;
  logic [GF_W-1:0]   out_rem;
  logic              out_valid;
  logic              busy;
  logic              accept;

  gf_fold #(.IN_W(PROD_W), .OUT_W(R1_W), .POLY_LOW(POLY_LOW)) u_fold1 (
    .din  (p_reg),
    .dout (r1_next)
  );

  gf_fold #(.IN_W(R1_W), .OUT_W(GF_W), .POLY_LOW(POLY_LOW)) u_fold2 (
    .din  (r1),
    .dout (rem_next)
  );

  // Accepting in VALID is only safe when the held result leaves on the same edge.
  assign bus.in_ready  = !rst && ((state == IDLE) || ((state == VALID) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_rem   = out_rem;
  assign bus.busy      = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_reg     <= '0;
      r1        <= '0;
      out_rem   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            p_reg <= bus.in_prod;
            state <= FOLD1;
            busy  <= 1'b1;
          end
        end
        FOLD1: begin
          r1    <= r1_next;
          state <= FOLD2;
        end
        FOLD2: begin
          out_rem   <= rem_next;
          out_valid <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              p_reg <= bus.in_prod;
              state <= FOLD1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gf64_reduce_seq.md
Name: gf64_reduce_seq

Overview:
Sequential GF(2^64) modular reducer that sits directly downstream of the 64-bit Karatsuba carry-less multiplier. It consumes the 127-bit polynomial product and folds it modulo P(x) = x^64 + POLY_LOW(x) over two registered fold stages. It returns the 64-bit field element through a valid/ready handshake. It is the consumer stage that turns the raw multiplier output into a field product for the GF datapath.

Parameters:
POLY_LOW, 32'h0000_001B, low terms of P(x); x^64 is implicit. The default gives x^64+x^4+x^3+x+1. Bit 0 must be 1. Degree must be <=31 so that two folds are sufficient.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  product valid
in_ready  out  1  block can accept a product this cycle
in_prod  in  127  carry-less product, bit i = coefficient of x^i
out_valid  out  1  reduced result valid
out_ready  in  1  downstream accepts the result
out_rem  out  64  in_prod mod P(x)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state goes to IDLE.
  - out_valid=0, out_rem=0, busy=0, and all internal registers are cleared.
  - in_ready is 0 while rst=1.
  - Reset mid-operation abandons the transaction silently; no output is produced for it.
- FSM states: IDLE, FOLD1, FOLD2, VALID.
  - IDLE: in_ready=1. If in_valid, latch in_prod into p_reg and go to FOLD1.
  - FOLD1: split p_reg into H=p_reg[126:64] (63b) and L=p_reg[63:0].
    - r1 = L ^ clmul(H, POLY_LOW), computed 95 bits wide.
    - Register r1 and go to FOLD2.
  - FOLD2: O = r1[94:64]. Result = r1[63:0] ^ clmul(O, POLY_LOW), truncated to 64 bits; bits above 63 are guaranteed zero.
    - Load out_rem, set out_valid=1, go to VALID.
  - VALID: hold out_rem and out_valid stable until out_ready.
    - in_ready = out_ready (combinational).
    - out_ready & in_valid: handshake out and accept the new product in the same edge, go to FOLD1, out_valid drops.
    - out_ready & !in_valid: go to IDLE, out_valid drops.
- Timing:
  - Latency: the accept edge is E0. out_valid rises after E2, i.e. visible in the cycle after the third rising edge counted from E0.
  - Peak throughput: 1 result per 3 cycles, with back-to-back accepts in VALID.
- Stability:
  - in_prod is sampled only at the accept edge and may change afterwards.
  - out_rem changes only on the FOLD2->VALID edge or on reset.
- Arithmetic:
  - All operations are XOR/AND, i.e. carry-less.
  - clmul(X, POLY_LOW) is the XOR of (X << k) for every set bit k of POLY_LOW.
  - No integer carries anywhere.
- Boundary cases:
  - in_prod=0 gives 0.
  - in_prod with H=0 passes L through unchanged after the full 3-cycle latency.
  - out_ready held low keeps the block stalled in VALID indefinitely with no loss of data.
  - in_valid while busy (outside IDLE/VALID) is ignored, because in_ready=0.

Decomposition:
- Shared package gf_pkg holds:
  - GF_W=64 and PROD_W=127
  - DEFAULT_POLY_LOW=32'h1B
  - state enum {IDLE, FOLD1, FOLD2, VALID}
  - a clmul_const function (variable operand times constant taps)
- One natural sub-module, gf_fold: a combinational single fold, parameterised on input width and POLY_LOW. It is instantiated twice, once for FOLD1 and once for FOLD2.
- The FSM and handshake stay in gf64_reduce_seq.

Test Plan:
1. Reset then single op: in_prod = 1<<64 (x^64), out_ready=1 -> out_rem=64'h0000_0000_0000_001B, out_valid high exactly 3 edges after accept.
2. Top bit: in_prod = 1<<126 -> out_rem=64'hC000_0000_0000_005A.
3. Pass-through: in_prod = 127'h1234_5678_9ABC_DEF0 (H=0) -> out_rem=64'h1234_5678_9ABC_DEF0. Also in_prod=0 -> out_rem=0.
4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a second product waiting.
   - in_ready=0 throughout, out_rem stable.
   - On out_ready=1, the second product is accepted on the same edge, and its result arrives 3 edges later.
5. Reset mid-operation: assert rst during FOLD2 -> next cycle out_valid=0, out_rem=0, in_ready=1 after rst deasserts, and no stale result is emitted.
6. Randomised 1000 products vs a software carry-less mod-P model, with random out_ready/in_valid gaps -> all results match, in order, with none dropped or duplicated.
